// File: rtl/rsa_modexp.sv
// rtl/rsa_modexp.sv - bit-serial square-and-multiply modular exponentiation engine
//
// Computes result = base^exponent mod modulus. It uses left-to-right
// square-and-multiply over an interleaved (Blakley) modular multiplier that
// consumes one multiplier bit per cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   operand set presented (base, exponent, modulus)
//   in_ready   engine idle and able to accept operands
//   base       WIDTH-bit base, any value (may exceed modulus)
//   exponent   EXP_WIDTH-bit exponent
//   modulus    WIDTH-bit modulus
//   out_valid  result and error valid; held until out_ready
//   out_ready  downstream accepts the result
//   result     WIDTH-bit base^exponent mod modulus
//   error      modulus was zero; qualified by out_valid
module rsa_modexp #(
    parameter int WIDTH     = 2048,
    parameter int EXP_WIDTH = 2048
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 error
);
    localparam int MW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int KW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam int PW = WIDTH + 2;

    typedef enum logic [2:0] {IDLE, REDUCE, SQR, MUL, DONE} state_t;

    state_t               state;
    state_t               state_nxt;

    logic [WIDTH-1:0]     n_r;      // modulus
    logic [WIDTH-1:0]     b_r;      // raw base during REDUCE, base mod n afterwards
    logic [WIDTH-1:0]     acc_r;    // running exponentiation result
    logic [EXP_WIDTH-1:0] exp_r;
    logic [KW-1:0]        k_r;      // exponent bit index
    logic [MW-1:0]        m_r;      // multiplier bit index, MSB first
    logic [WIDTH-1:0]     p_r;      // partial product, always < n between cycles

    logic                 deliver;
    logic                 degenerate;
    logic                 mul_last;
    logic                 last_bit;
    logic                 exp_bit;
    logic                 y_bit;
    logic [WIDTH-1:0]     x_op;
    logic [WIDTH-1:0]     y_op;
    logic [PW-1:0]        n_ext;
    logic [PW-1:0]        p_sum;
    logic [PW-1:0]        p_sub1;
    logic [WIDTH-1:0]     p_new;

    assign in_ready   = (state == IDLE);
    assign deliver    = out_valid && out_ready;
    assign degenerate = (modulus <= WIDTH'(1));
    assign mul_last   = (m_r == '0);
    assign last_bit   = (k_r == '0);
    assign exp_bit    = exp_r[k_r];

    // REDUCE multiplies 1 by the raw base with the base as the scanned
    // operand: 2P+bit < 2n, so an unreduced base never breaks the P < n
    // invariant. SQR/MUL add an operand already < n, so 2P+X < 3n and two
    // conditional subtractions suffice.
    assign x_op  = (state == REDUCE) ? WIDTH'(1) : acc_r;
    assign y_op  = (state == SQR) ? acc_r : b_r;
    assign y_bit = y_op[m_r];
    assign n_ext = {2'b00, n_r};

    assign p_sum  = {1'b0, p_r, 1'b0} + (y_bit ? {2'b00, x_op} : '0);
    assign p_sub1 = (p_sum >= n_ext) ? (p_sum - n_ext) : p_sum;
    assign p_new  = WIDTH'((p_sub1 >= n_ext) ? (p_sub1 - n_ext) : p_sub1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = degenerate ? DONE : REDUCE;
                end
            end
            REDUCE: begin
                if (mul_last) begin
                    state_nxt = SQR;
                end
            end
            SQR: begin
                if (mul_last) begin
                    if (exp_bit) begin
                        state_nxt = MUL;
                    end else if (last_bit) begin
                        state_nxt = DONE;
                    end
                end
            end
            MUL: begin
                if (mul_last) begin
                    state_nxt = last_bit ? DONE : SQR;
                end
            end
            DONE: begin
                if (deliver) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            n_r       <= '0;
            b_r       <= '0;
            acc_r     <= '0;
            exp_r     <= '0;
            k_r       <= '0;
            m_r       <= '0;
            p_r       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        n_r   <= modulus;
                        b_r   <= base;
                        exp_r <= exponent;
                        acc_r <= degenerate ? '0 : WIDTH'(1);
                        error <= (modulus == '0);
                        k_r   <= KW'(EXP_WIDTH - 1);
                        m_r   <= MW'(WIDTH - 1);
                        p_r   <= '0;
                    end
                end
                REDUCE, SQR, MUL: begin
                    if (mul_last) begin
                        p_r <= '0;
                        m_r <= MW'(WIDTH - 1);
                        if (state == REDUCE) begin
                            b_r <= p_new;
                        end else begin
                            acc_r <= p_new;
                        end
                        // A set bit keeps k for its MUL pass; otherwise step on.
                        if ((state == SQR && !exp_bit && !last_bit) ||
                            (state == MUL && !last_bit)) begin
                            k_r <= k_r - KW'(1);
                        end
                    end else begin
                        p_r <= p_new;
                        m_r <= m_r - MW'(1);
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; it then holds
                    // under backpressure until the handshake.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        result    <= acc_r;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        error     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_modexp.sv
// tb/tb_rsa_modexp.sv - self-checking bench for rsa_modexp
module tb_rsa_modexp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, iv8, ir8, ov8, or8, er8;
    logic [7:0]  b8, e8, m8, r8;
    logic        rst32, iv32, ir32, ov32, or32, er32;
    logic [31:0] b32, m32, r32;
    logic [15:0] e32;

    rsa_modexp #(.WIDTH(8), .EXP_WIDTH(8)) dut8 (
        .clk(clk), .reset(rst8), .in_valid(iv8), .in_ready(ir8),
        .base(b8), .exponent(e8), .modulus(m8),
        .out_valid(ov8), .out_ready(or8), .result(r8), .error(er8)
    );

    rsa_modexp #(.WIDTH(32), .EXP_WIDTH(16)) dut32 (
        .clk(clk), .reset(rst32), .in_valid(iv32), .in_ready(ir32),
        .base(b32), .exponent(e32), .modulus(m32),
        .out_valid(ov32), .out_ready(or32), .result(r32), .error(er32)
    );

    typedef struct {
        longint unsigned res;
        bit              err;
        int              lat;
        int              acc;
    } exp_t;

    exp_t sb [2][$];
    bit   prev_v [2];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   rdy_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint unsigned ref_modexp(input longint unsigned b, input longint unsigned e,
                                                   input longint unsigned n);
        longint unsigned r, s, x;
        if (n < 2) return 0;
        r = 1;
        s = b % n;
        x = e;
        while (x != 0) begin
            if (x[0]) r = (r * s) % n;
            s = (s * s) % n;
            x = x >> 1;
        end
        return r % n;
    endfunction

    function automatic int ref_lat(input longint unsigned e, input int w, input int ew,
                                   input longint unsigned n);
        if (n < 2) return 1;
        return w * (1 + ew + $countones(e)) + 1;
    endfunction

    task automatic observe(input int id, input logic ov, input logic ir, input logic er,
                           input longint unsigned res, input logic ordy);
        exp_t f;
        if (sb[id].size() == 0) begin
            chk($sformatf("idle_out_valid[%0d]", id), ov, 0);
        end else begin
            f = sb[id][0];
            chk($sformatf("busy_in_ready[%0d]", id), ir, 0);
            if (ov) begin
                chk($sformatf("result[%0d]", id), res, f.res);
                chk($sformatf("error[%0d]", id), er, f.err);
                if (!prev_v[id]) chk($sformatf("latency[%0d]", id), cyc - f.acc, f.lat);
                if (ordy) void'(sb[id].pop_front());
            end else if (cyc - f.acc == f.lat) begin
                chk($sformatf("late_out_valid[%0d]", id), ov, 1);
            end
        end
        prev_v[id] = ov;
    endtask

    always @(negedge clk) begin
        observe(0, ov8, ir8, er8, {56'b0, r8}, or8);
        observe(1, ov32, ir32, er32, {32'b0, r32}, or32);
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_rand) or32 = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic submit8(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m, input exp_t x);
        int t = 0;
        b8 = b; e8 = e; m8 = m; iv8 = 1'b1;
        @(negedge clk);
        while (!ir8 && t < 2000) begin @(negedge clk); t++; end
        chk("accept8", ir8, 1);
        @(posedge clk);
        #2;
        iv8 = 1'b0;
        if (t < 2000) begin
            x.acc = cyc;
            sb[0].push_back(x);
        end
    endtask

    task automatic submit32(input logic [31:0] b, input logic [15:0] e, input logic [31:0] m, input exp_t x);
        int t = 0;
        b32 = b; e32 = e; m32 = m; iv32 = 1'b1;
        @(negedge clk);
        while (!ir32 && t < 5000) begin @(negedge clk); t++; end
        chk("accept32", ir32, 1);
        @(posedge clk);
        #2;
        iv32 = 1'b0;
        if (t < 5000) begin
            x.acc = cyc;
            sb[1].push_back(x);
        end
    endtask

    task automatic wait_idle(input int id, input int bound);
        int t = 0;
        while (sb[id].size() != 0 && t < bound) begin @(posedge clk); #2; t++; end
        chk($sformatf("drain[%0d]", id), sb[id].size(), 0);
    endtask

    task automatic run8(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                        input longint unsigned res, input bit err, input int lat, input bit bp);
        exp_t x;
        int   t = 0;
        chk("model_result", ref_modexp(b, e, m), res);
        chk("model_latency", ref_lat(e, 8, 8, m), lat);
        x.res = res; x.err = err; x.lat = lat; x.acc = 0;
        if (bp) or8 = 1'b0;
        submit8(b, e, m, x);
        if (bp) begin
            while (!ov8 && t < 500) begin @(posedge clk); #2; t++; end
            chk("bp_seen_valid", ov8, 1);
            repeat (20) begin @(posedge clk); #2; end
            chk("bp_hold_valid", ov8, 1);
            chk("bp_hold_result", r8, res);
            chk("bp_hold_in_ready", ir8, 0);
            or8 = 1'b1;
        end
        wait_idle(0, 500);
    endtask

    initial begin
        exp_t        x;
        logic [31:0] rb, rn;
        logic [15:0] re;
        int          gap;

        rst8 = 1'b1; rst32 = 1'b1; iv8 = 1'b0; iv32 = 1'b0; or8 = 1'b1; or32 = 1'b1;
        b8 = '0; e8 = '0; m8 = '0; b32 = '0; e32 = '0; m32 = '0;
        repeat (3) @(posedge clk);
        #2;
        rst8 = 1'b0; rst32 = 1'b0;
        chk("rst_in_ready8", ir8, 1);
        chk("rst_out_valid8", ov8, 0);
        chk("rst_result8", r8, 0);
        chk("rst_error8", er8, 0);
        chk("rst_in_ready32", ir32, 1);
        chk("rst_out_valid32", ov32, 0);
        chk("rst_result32", r32, 0);

        //    base exp  mod  result err latency backpressure
        run8(  4,  13,   7,  4,     0,  97,     0);
        run8(  4,   3,  33, 31,     0,  89,     1);
        run8( 31,   7,  33,  4,     0,  97,     0);
        run8(200,   1,   7,  4,     0,  81,     0);
        run8(  5,   0,   7,  1,     0,  73,     0);

        // Abort (4,13,7) during the squaring of exponent bit 4.
        x.res = 4; x.err = 0; x.lat = 97; x.acc = 0;
        submit8(8'd4, 8'd13, 8'd7, x);
        repeat (34) begin @(posedge clk); #2; end
        rst8 = 1'b1;
        sb[0].delete();
        @(posedge clk);
        #2;
        rst8 = 1'b0;
        chk("abort_in_ready", ir8, 1);
        chk("abort_out_valid", ov8, 0);
        chk("abort_result", r8, 0);
        chk("abort_error", er8, 0);

        run8(  4,  13,   7,  4,     0,  97,     0);
        run8( 77,   5,   0,  0,     1,   1,     0);
        run8(  9,   5,   1,  0,     0,   1,     0);

        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rb = $urandom;
            re = 16'($urandom);
            rn = $urandom;
            if (i == 0) begin rb = 32'hFFFF_FFFE; re = 16'hFFFF; rn = 32'hFFFF_FFFF; end
            if (i == 1) re = 16'h0000;
            if (i == 2) rn = 32'd2;
            if (rn < 2) rn = rn + 32'd2;
            x.res = ref_modexp(rb, re, rn);
            x.err = 1'b0;
            x.lat = ref_lat(re, 32, 16, rn);
            x.acc = 0;
            gap = $urandom_range(0, 3);
            repeat (gap) begin @(posedge clk); #2; end
            submit32(rb, re, rn, x);
        end
        wait_idle(1, 5000);
        rdy_rand = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
